// File: rtl/hazard_collision_scanner.sv
// hazard_collision_scanner
//
// Once per video frame this block walks the hazard table. It tests each
// active hazard's bounding box against the player's box. On the first
// overlap it emits a one-cycle collision pulse for the lives counter. It then
// holds an invincibility window, measured in frame ticks, and drives a sprite
// blink flag during that window.
//
// Ports
//   i_Clk, i_Reset    clock; synchronous active-high reset
//   i_Frame_Tick      one-cycle strobe per frame (end of active video)
//   i_Enable          scanning allowed; when low the block returns to IDLE
//   i_Player_X/Y      player top-left, latched at the start of each scan
//   o_Hazard_Idx      hazard table read address
//   i_Hazard_X/Y      hazard top-left at o_Hazard_Idx (same-cycle read)
//   i_Hazard_Active   entry valid at o_Hazard_Idx (same-cycle read)
//   o_Collision       one-cycle hit pulse (registered)
//   o_Hit_Idx         index of the last hazard hit
//   o_Invincible      high during the cooldown window
//   o_Blink           sprite-hide flag during cooldown
//   o_Busy            high while the table is being scanned
//
// Table protocol: there is no handshake. The table is an asynchronous read
// port. Whatever i_Hazard_* presents in a SCAN cycle is taken as the contents
// of entry o_Hazard_Idx for that same cycle.

module hazard_collision_scanner #(
    parameter int COORD_W         = 10,
    parameter int PLAYER_W        = 16,
    parameter int PLAYER_H        = 16,
    parameter int HAZARD_W        = 16,
    parameter int HAZARD_H        = 16,
    parameter int NUM_HAZARDS     = 8,
    parameter int COOLDOWN_FRAMES = 90,
    parameter int BLINK_FRAMES    = 8,
    localparam int IDX_W = (NUM_HAZARDS > 1) ? $clog2(NUM_HAZARDS) : 1
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Frame_Tick,
    input  logic               i_Enable,
    input  logic [COORD_W-1:0] i_Player_X,
    input  logic [COORD_W-1:0] i_Player_Y,
    output logic [IDX_W-1:0]   o_Hazard_Idx,
    input  logic [COORD_W-1:0] i_Hazard_X,
    input  logic [COORD_W-1:0] i_Hazard_Y,
    input  logic               i_Hazard_Active,
    output logic               o_Collision,
    output logic [IDX_W-1:0]   o_Hit_Idx,
    output logic               o_Invincible,
    output logic               o_Blink,
    output logic               o_Busy
);

    localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
    localparam int BC_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_HAZARDS - 1);
    localparam logic [CD_W-1:0]    CD_LOAD    = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0]    CD_ONE     = CD_W'(1);
    localparam logic [BC_W-1:0]    BLINK_WRAP = BC_W'(BLINK_FRAMES);

    // Box sizes widened to COORD_W+1 bits so coordinate sums never wrap.
    localparam logic [COORD_W:0] PW_E = (COORD_W+1)'(PLAYER_W);
    localparam logic [COORD_W:0] PH_E = (COORD_W+1)'(PLAYER_H);
    localparam logic [COORD_W:0] HW_E = (COORD_W+1)'(HAZARD_W);
    localparam logic [COORD_W:0] HH_E = (COORD_W+1)'(HAZARD_H);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN     = 2'd1,
        ST_HIT      = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [IDX_W-1:0]   hit_idx_q,   hit_idx_d;
    logic [COORD_W-1:0] px_q,        px_d;
    logic [COORD_W-1:0] py_q,        py_d;
    logic [CD_W-1:0]    cooldown_q,  cooldown_d;
    logic [BC_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic               blink_q,     blink_d;

    // Overlap test for the entry currently on the read port.
    logic [COORD_W:0] px_e, py_e, hx_e, hy_e;
    logic             hit;
    logic [BC_W-1:0]  blink_cnt_inc;

    assign px_e = {1'b0, px_q};
    assign py_e = {1'b0, py_q};
    assign hx_e = {1'b0, i_Hazard_X};
    assign hy_e = {1'b0, i_Hazard_Y};

    // Strict less-than comparisons: boxes that share only an edge do not hit.
    assign hit = i_Hazard_Active
               && (px_e < hx_e + HW_E)
               && (hx_e < px_e + PW_E)
               && (py_e < hy_e + HH_E)
               && (hy_e < py_e + PH_E);

    assign blink_cnt_inc = blink_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hit_idx_d   = hit_idx_q;
        px_d        = px_q;
        py_d        = py_q;
        cooldown_d  = cooldown_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;

        if (!i_Enable) begin
            // Abort from any state. A hit seen in this cycle is dropped
            // because the next state is IDLE rather than HIT.
            state_d = ST_IDLE;
            blink_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_Frame_Tick) begin
                        px_d    = i_Player_X;
                        py_d    = i_Player_Y;
                        idx_d   = '0;
                        state_d = ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    // First hit wins; the rest of the table is skipped.
                    if (hit) begin
                        hit_idx_d = idx_q;
                        state_d   = ST_HIT;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end

                ST_HIT: begin
                    cooldown_d  = CD_LOAD;
                    blink_cnt_d = '0;
                    blink_d     = 1'b1;
                    state_d     = ST_COOLDOWN;
                end

                ST_COOLDOWN: begin
                    if (i_Frame_Tick) begin
                        if (cooldown_q == CD_ONE) begin
                            // The closing tick only ends the window. It does
                            // not also start a scan.
                            cooldown_d = '0;
                            blink_d    = 1'b0;
                            state_d    = ST_IDLE;
                        end else begin
                            cooldown_d = cooldown_q - 1'b1;
                            if (blink_cnt_inc == BLINK_WRAP) begin
                                blink_cnt_d = '0;
                                blink_d     = ~blink_q;
                            end else begin
                                blink_cnt_d = blink_cnt_inc;
                            end
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            hit_idx_q   <= '0;
            px_q        <= '0;
            py_q        <= '0;
            cooldown_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hit_idx_q   <= hit_idx_d;
            px_q        <= px_d;
            py_q        <= py_d;
            cooldown_q  <= cooldown_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // Every output is a flop or a decode of the state register. The HIT state
    // lasts exactly one cycle, so o_Collision is a registered single pulse.
    assign o_Hazard_Idx = idx_q;
    assign o_Hit_Idx    = hit_idx_q;
    assign o_Collision  = (state_q == ST_HIT);
    assign o_Invincible = (state_q == ST_COOLDOWN);
    assign o_Blink      = blink_q;
    assign o_Busy       = (state_q == ST_SCAN);

endmodule
